// File: rtl/serial_add_scheduler.sv
// ---------------------------------------------------------------------------
// serial_add_scheduler
//
// Purpose:
//   Two requesters compete for one bit-serial adder. In IDLE one requester is
//   granted and its operand pair is latched. The pair is then added one bit per
//   clock, LSB first, through a 1-bit full adder that keeps its carry in a
//   register. The finished sum, carry-out and owner id are held on the result
//   port until the consumer accepts them.
//
// Configuration macro:
//   SERIAL_ADD_SCHED_RR_EN
//     defined   : round-robin arbitration between req0 and req1
//     undefined : fixed priority, req0 always wins (no pointer state)
//
// Parameters:
//   WIDTH      operand/result width in bits (2..32)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req0_vld   requester 0 has an operand pair pending
//   req0_rdy   requester 0 operands accepted this cycle (combinational)
//   req0_a/b   requester 0 operands
//   req1_vld   requester 1 has an operand pair pending
//   req1_rdy   requester 1 operands accepted this cycle (combinational)
//   req1_a/b   requester 1 operands
//   res_vld    result available
//   res_rdy    consumer accepts the result
//   res_sum    sum modulo 2^WIDTH
//   res_carry  carry out of bit WIDTH-1
//   res_id     requester that owns the result
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// serial_bit_adder
//   1-bit full adder with a carry register. The carry is updated only on
//   cycles with vld=1. On the last bit the carry is cleared, so the next
//   operation starts from carry 0.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   vld         a bit pair is presented this cycle
//   last        this bit pair is the most significant one
//   a, b        operand bits
//   sum         sum bit (combinational)
//   cout        carry out of this bit position (combinational)
// ---------------------------------------------------------------------------
module serial_bit_adder (
  input  logic clk,
  input  logic rst_n,
  input  logic vld,
  input  logic last,
  input  logic a,
  input  logic b,
  output logic sum,
  output logic cout
);

  logic carry_q;
  logic carry_d;

  always_comb begin
    sum  = a ^ b ^ carry_q;
    cout = (a & b) | (a & carry_q) | (b & carry_q);
    carry_d = carry_q;
    if (vld) begin
      carry_d = last ? 1'b0 : cout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
    end else begin
      carry_q <= carry_d;
    end
  end

endmodule

module serial_add_scheduler #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_vld,
  output logic             req0_rdy,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_vld,
  output logic             req1_rdy,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             res_vld,
  input  logic             res_rdy,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_carry,
  output logic             res_id
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q,     state_d;
  logic [CW-1:0]    bit_cnt_q,   bit_cnt_d;
  logic [WIDTH-1:0] a_q,         a_d;
  logic [WIDTH-1:0] b_q,         b_d;
  logic             id_q,        id_d;
  logic [WIDTH-1:0] sum_q,       sum_d;
  logic             res_carry_q, res_carry_d;
  logic             res_vld_q,   res_vld_d;

  logic grant0;
  logic grant1;
  logic fa_vld;
  logic fa_last;
  logic fa_a;
  logic fa_b;
  logic fa_sum;
  logic fa_cout;

`ifdef SERIAL_ADD_SCHED_RR_EN
  // Pointer: 0 favours req0, 1 favours req1 on a contested cycle.
  logic rr_q;
  logic rr_d;
`endif

  // Arbitration. Only meaningful in IDLE; the FSM ignores it elsewhere.
  always_comb begin
`ifdef SERIAL_ADD_SCHED_RR_EN
    grant1 = req1_vld && (!req0_vld || rr_q);
`else
    grant1 = req1_vld && !req0_vld;
`endif
    grant0 = req0_vld && !grant1;
  end

  // Ready is combinational in the acceptance cycle. It is gated with rst_n
  // because the state register already reads IDLE while reset is held.
  assign req0_rdy = rst_n && (state_q == IDLE) && grant0;
  assign req1_rdy = rst_n && (state_q == IDLE) && grant1;

  serial_bit_adder u_bit_adder (
    .clk   (clk),
    .rst_n (rst_n),
    .vld   (fa_vld),
    .last  (fa_last),
    .a     (fa_a),
    .b     (fa_b),
    .sum   (fa_sum),
    .cout  (fa_cout)
  );

  // Next-state logic. Operands are latched only in the grant cycle. After that
  // the requester inputs have no effect until the FSM returns to IDLE.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    sum_d       = sum_q;
    res_carry_d = res_carry_q;
    res_vld_d   = res_vld_q;
    fa_vld      = 1'b0;
    fa_last     = 1'b0;
    fa_a        = a_q[bit_cnt_q];
    fa_b        = b_q[bit_cnt_q];
`ifdef SERIAL_ADD_SCHED_RR_EN
    rr_d        = rr_q;
`endif

    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          a_d       = grant1 ? req1_a : req0_a;
          b_d       = grant1 ? req1_b : req0_b;
          id_d      = grant1;
          bit_cnt_d = '0;
          state_d   = RUN;
`ifdef SERIAL_ADD_SCHED_RR_EN
          // Hand priority to the requester that just lost.
          rr_d      = grant0;
`endif
        end
      end

      RUN: begin
        fa_vld           = 1'b1;
        fa_last          = (bit_cnt_q == LAST_BIT);
        sum_d[bit_cnt_q] = fa_sum;
        if (bit_cnt_q == LAST_BIT) begin
          res_carry_d = fa_cout;
          res_vld_d   = 1'b1;
          bit_cnt_d   = '0;
          state_d     = DONE;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end

      DONE: begin
        if (res_rdy) begin
          res_vld_d = 1'b0;
          state_d   = IDLE;
        end
      end

      default: begin
        state_d   = IDLE;
        res_vld_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= 1'b0;
      sum_q       <= '0;
      res_carry_q <= 1'b0;
      res_vld_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      sum_q       <= sum_d;
      res_carry_q <= res_carry_d;
      res_vld_q   <= res_vld_d;
    end
  end

`ifdef SERIAL_ADD_SCHED_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

  // The id register is written only on a grant, so it is stable in DONE.
  assign res_vld   = res_vld_q;
  assign res_sum   = sum_q;
  assign res_carry = res_carry_q;
  assign res_id    = id_q;

endmodule

// File: tb/tb_serial_add_scheduler.sv
// ---------------------------------------------------------------------------
// tb_serial_add_scheduler
//   Self-checking bench for serial_add_scheduler at WIDTH=8. Expected results
//   are computed from the operands when an offer is accepted and queued. They
//   are popped and compared when the DUT presents res_vld.
// ---------------------------------------------------------------------------
module tb_serial_add_scheduler;

  logic       clk;
  logic       rst_n;
  logic       req0_vld;
  logic       req0_rdy;
  logic [7:0] req0_a;
  logic [7:0] req0_b;
  logic       req1_vld;
  logic       req1_rdy;
  logic [7:0] req1_a;
  logic [7:0] req1_b;
  logic       res_vld;
  logic       res_rdy;
  logic [7:0] res_sum;
  logic       res_carry;
  logic       res_id;

  typedef struct {
    logic [7:0] sum;
    logic       carry;
    logic       id;
  } exp_t;

  exp_t sb[$];
  int   n_checks;
  int   n_fail;

  serial_add_scheduler #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0_vld  (req0_vld),
    .req0_rdy  (req0_rdy),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req1_vld  (req1_vld),
    .req1_rdy  (req1_rdy),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .res_vld   (res_vld),
    .res_rdy   (res_rdy),
    .res_sum   (res_sum),
    .res_carry (res_carry),
    .res_id    (res_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present an operand pair from a negedge and wait (bounded) for its ready.
  // On acceptance, push the reference result and return 1 ns after the
  // accepting edge with the valid dropped.
  task automatic offer(input bit idx, input logic [7:0] a, input logic [7:0] b,
                       output bit ok);
    exp_t       e;
    logic [8:0] full;
    ok = 1'b0;
    if (idx) begin
      req1_vld = 1'b1; req1_a = a; req1_b = b;
    end else begin
      req0_vld = 1'b1; req0_a = a; req0_b = b;
    end
    for (int i = 0; i < 40 && !ok; i++) begin
      #1;
      if ((idx && req1_rdy === 1'b1) || (!idx && req0_rdy === 1'b1)) ok = 1'b1;
      else @(negedge clk);
    end
    if (ok) begin
      full    = {1'b0, a} + {1'b0, b};
      e.sum   = full[7:0];
      e.carry = full[8];
      e.id    = idx;
      sb.push_back(e);
      @(posedge clk);
      #1;
    end
    if (idx) req1_vld = 1'b0;
    else     req0_vld = 1'b0;
  endtask

  // Advance by negedges until res_vld is seen, bounded.
  task automatic wait_result(output bit ok, output int cycles);
    ok = 1'b0;
    cycles = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      cycles++;
      if (res_vld === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; res_rdy = 1'b1;
    req0_vld = 1'b1; req1_vld = 1'b1;
    req0_a = 8'h00; req0_b = 8'h00; req1_a = 8'h00; req1_b = 8'h00;
    #12;
    n_checks++;
    if (req0_rdy !== 1'b0 || req1_rdy !== 1'b0 || res_vld !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_handshake got rdy0=%b rdy1=%b vld=%b want 0 0 0",
               req0_rdy, req1_rdy, res_vld);
    end
    n_checks++;
    if (res_sum !== 8'h00 || res_carry !== 1'b0 || res_id !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_result got sum=%h c=%b id=%b want 00 0 0",
               res_sum, res_carry, res_id);
    end
    req0_vld = 1'b0; req1_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    bit   ok;
    int   errs;
    exp_t e;
    @(negedge clk);
    offer(1'b0, 8'h5A, 8'h33, ok);
    n_checks++;
    if (ok !== 1'b1) begin
      n_fail++; $display("[TB] FAIL basic_accept got %b want 1", ok);
    end
    errs = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (res_vld !== 1'b0) errs++;
    end
    @(negedge clk);
    n_checks++;
    if (errs != 0 || res_vld !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL basic_latency got early=%0d vld=%b want early=0 vld=1", errs, res_vld);
    end
    if (ok && sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      if (res_sum !== e.sum || res_carry !== e.carry || res_id !== e.id) begin
        n_fail++;
        $display("[TB] FAIL basic_result got %h/%b/%b want %h/%b/%b",
                 res_sum, res_carry, res_id, e.sum, e.carry, e.id);
      end
    end
    n_checks++;
    if (res_sum !== 8'h8D || res_carry !== 1'b0 || res_id !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL basic_const got %h/%b/%b want 8d/0/0", res_sum, res_carry, res_id);
    end
    @(negedge clk);
    n_checks++;
    if (res_vld !== 1'b0) begin
      n_fail++; $display("[TB] FAIL basic_consumed got vld=%b want 0", res_vld);
    end
  endtask

  task automatic test_carry;
    bit         ok;
    bit         got;
    int         cyc;
    exp_t       e;
    logic [7:0] ta [2];
    logic [7:0] tb [2];
    ta[0] = 8'hFF; tb[0] = 8'h01;
    ta[1] = 8'h01; tb[1] = 8'h01;
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      offer(1'b1, ta[t], tb[t], ok);
      wait_result(got, cyc);
      n_checks++;
      if (!ok || !got || sb.size() == 0) begin
        n_fail++; $display("[TB] FAIL carry_timeout got accept=%b result=%b want 1 1", ok, got);
      end else begin
        e = sb.pop_front();
        if (res_sum !== e.sum || res_carry !== e.carry || res_id !== e.id) begin
          n_fail++;
          $display("[TB] FAIL carry_result%0d got %h/%b/%b want %h/%b/%b", t,
                   res_sum, res_carry, res_id, e.sum, e.carry, e.id);
        end
      end
    end
    n_checks++;
    if (res_sum !== 8'h02 || res_carry !== 1'b0) begin
      n_fail++; $display("[TB] FAIL carry_leak got %h/%b want 02/0", res_sum, res_carry);
    end
    @(negedge clk);
  endtask

  task automatic test_hold;
    bit   ok;
    bit   got;
    int   cyc;
    exp_t e;
    res_rdy = 1'b0;
    @(negedge clk);
    offer(1'b0, 8'hA5, 8'hC3, ok);
    wait_result(got, cyc);
    e.sum = 8'h00; e.carry = 1'b0; e.id = 1'b0;
    if (sb.size() > 0) e = sb.pop_front();
    n_checks++;
    if (!ok || !got || res_sum !== e.sum || res_carry !== e.carry || res_id !== e.id) begin
      n_fail++;
      $display("[TB] FAIL hold_result got %h/%b/%b want %h/%b/%b", res_sum, res_carry, res_id,
               e.sum, e.carry, e.id);
    end
    req0_vld = 1'b1; req0_a = 8'h11; req0_b = 8'h11;
    req1_vld = 1'b1; req1_a = 8'h22; req1_b = 8'h22;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (res_vld !== 1'b1 || res_sum !== e.sum || res_carry !== e.carry ||
          res_id !== e.id || req0_rdy !== 1'b0 || req1_rdy !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL hold_stall%0d got vld=%b %h/%b/%b rdy=%b%b want 1 %h/%b/%b 00", k,
                 res_vld, res_sum, res_carry, res_id, req0_rdy, req1_rdy, e.sum, e.carry, e.id);
      end
    end
    res_rdy = 1'b1;
    @(negedge clk);
    n_checks++;
    if (res_vld !== 1'b0 || (req0_rdy ^ req1_rdy) !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL hold_release got vld=%b rdy=%b%b want vld=0 one rdy", res_vld,
               req0_rdy, req1_rdy);
    end
    req0_vld = 1'b0; req1_vld = 1'b0;
  endtask

  task automatic test_back_to_back;
    bit         got;
    int         cyc;
    bit         e_id;
    exp_t       e;
    logic [8:0] full;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    res_rdy = 1'b1;
    req0_vld = 1'b1; req0_a = 8'h11; req0_b = 8'h22;
    req1_vld = 1'b1; req1_a = 8'h40; req1_b = 8'hC5;
    for (int op = 0; op < 4; op++) begin
`ifdef SERIAL_ADD_SCHED_RR_EN
      e_id = op[0];
`else
      e_id = 1'b0;
`endif
      #1;
      n_checks++;
      if (req0_rdy !== !e_id || req1_rdy !== e_id) begin
        n_fail++;
        $display("[TB] FAIL b2b_grant%0d got rdy=%b%b want id %0d", op, req0_rdy, req1_rdy, e_id);
      end
      full    = e_id ? ({1'b0, req1_a} + {1'b0, req1_b}) : ({1'b0, req0_a} + {1'b0, req0_b});
      e.sum   = full[7:0];
      e.carry = full[8];
      e.id    = e_id;
      sb.push_back(e);
      wait_result(got, cyc);
      e = sb.pop_front();
      n_checks++;
      if (!got || cyc != 9 || res_sum !== e.sum || res_carry !== e.carry || res_id !== e.id) begin
        n_fail++;
        $display("[TB] FAIL b2b_result%0d got %h/%b/%b after %0d want %h/%b/%b after 9", op,
                 res_sum, res_carry, res_id, cyc, e.sum, e.carry, e.id);
      end
      @(negedge clk);
    end
    req0_vld = 1'b0; req1_vld = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    bit   ok;
    bit   got;
    int   cyc;
    int   seen;
    exp_t e;
    @(negedge clk);
    offer(1'b0, 8'h77, 8'h88, ok);
    for (int k = 0; k < 4; k++) @(negedge clk);
    req1_vld = 1'b1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (res_vld !== 1'b0 || req0_rdy !== 1'b0 || req1_rdy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL midrun_reset got vld=%b rdy=%b%b want 0 00", res_vld, req0_rdy, req1_rdy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req1_vld = 1'b0;
    sb.delete();
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (res_vld !== 1'b0) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++; $display("[TB] FAIL midrun_abandon got %0d result cycles want 0", seen);
    end
    offer(1'b0, 8'h10, 8'h20, ok);
    wait_result(got, cyc);
    n_checks++;
    if (!ok || !got || sb.size() == 0) begin
      n_fail++; $display("[TB] FAIL midrun_next got accept=%b result=%b want 1 1", ok, got);
    end else begin
      e = sb.pop_front();
      if (res_sum !== e.sum || res_carry !== e.carry || res_sum !== 8'h30 || res_id !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL midrun_next got %h/%b/%b want 30/0/0", res_sum, res_carry, res_id);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    bit         ok;
    bit         got;
    int         cyc;
    bit         idx;
    logic [7:0] a;
    logic [7:0] b;
    exp_t       e;
    for (int t = 0; t < 8; t++) begin
      idx = 1'($urandom_range(0, 1));
      a   = 8'($urandom);
      b   = 8'($urandom);
      @(negedge clk);
      offer(idx, a, b, ok);
      wait_result(got, cyc);
      n_checks++;
      if (!ok || !got || sb.size() == 0) begin
        n_fail++; $display("[TB] FAIL random%0d_timeout got accept=%b result=%b want 1 1", t, ok, got);
      end else begin
        e = sb.pop_front();
        if (res_sum !== e.sum || res_carry !== e.carry || res_id !== e.id) begin
          n_fail++;
          $display("[TB] FAIL random%0d got %h/%b/%b want %h/%b/%b (a=%h b=%h)", t,
                   res_sum, res_carry, res_id, e.sum, e.carry, e.id, a, b);
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_carry();
    test_hold();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
